slot_alloc: RTL and testbench
=============================

SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
- REQ-001: Parameter INWD SHALL default to 8 (from DEF.sv) and set the number of allocatable slots (3..10).
- REQ-002: Parameter LOGINWD SHALL default to 3 (from DEF.sv) and set the width of a slot index (ceil(log2(INWD))).
- REQ-003: clk  input  1  SHALL be the single clock; all state updates on rising edge.
- REQ-004: rst_n  input  1  SHALL be the reset: synchronous, active-low.
- REQ-005: alloc_req  input  1  SHALL request one free slot in the current cycle.
- REQ-006: alloc_ack  output  1  SHALL be a registered one-cycle pulse: a slot was granted.
- REQ-007: alloc_idx  output  LOGINWD  SHALL be the registered index of the granted slot, valid while alloc_ack=1.
- REQ-008: rel_valid  input  1  SHALL qualify a slot release.
- REQ-009: rel_idx  input  LOGINWD  SHALL give the index of the slot to release.
- REQ-010: busy_map  output  INWD  SHALL be the registered occupancy vector; bit i=1 means slot i is allocated.
- REQ-011: count  output  LOGINWD+1  SHALL be the registered number of allocated slots.
- REQ-012: full  output  1  SHALL be 1 when busy_map is all ones.
- REQ-013: empty  output  1  SHALL be 1 when busy_map is all zeros.
- REQ-014: rel_err  output  1  SHALL be a registered one-cycle pulse flagging an illegal release.

Function
- REQ-015: The selected slot SHALL be the index of the least-significant 0 in the current busy_map (lowest free slot first).
- REQ-016: An allocation SHALL be accepted in cycle N iff alloc_req=1 and full=0, both sampled in cycle N.
- REQ-017: On acceptance in cycle N, the selected bit SHALL be set in busy_map at N+1; alloc_ack=1 and alloc_idx=selected index SHALL appear at N+1 (1-cycle latency).
- REQ-018: At most one allocation SHALL be granted per cycle; alloc_req held high SHALL yield consecutive grants of ascending free indices until full.
- REQ-019: If alloc_req=1 while full=1, the request SHALL be dropped; alloc_ack=0 next cycle; no state change; no retry memory.
- REQ-020: When alloc_ack=0, alloc_idx SHALL hold its previous value.
- REQ-021: A release SHALL be legal iff rel_valid=1, rel_idx<INWD, and busy_map[rel_idx]=1; a legal release SHALL clear that bit at N+1.
- REQ-022: An illegal release (index >= INWD, or slot already free) SHALL change no state and SHALL pulse rel_err at N+1.
- REQ-023: With a simultaneous allocation and legal release, selection SHALL use the pre-release busy_map. Next busy_map SHALL be (busy_map | set_bit) & ~clr_bit. count SHALL be unchanged.
- REQ-024: A release in the same cycle as an allocation attempt while full=1 SHALL NOT make that attempt succeed; the freed slot becomes available from N+1.
- REQ-025: count SHALL increment by 1 on accept-only, decrement by 1 on legal-release-only, and stay unchanged otherwise. count SHALL always equal the popcount of busy_map.
- REQ-026: full and empty SHALL be derived combinationally from registered busy_map (no extra latency).

Reset
- REQ-027: When rst_n=0 at a rising edge, the block SHALL set busy_map=0, count=0, alloc_ack=0, alloc_idx=0, and rel_err=0, so that full=0 and empty=1.
- REQ-028: Reset SHALL override any alloc_req or rel_valid in the same cycle; grants or releases in flight SHALL be discarded.

Verification (INWD=8)
- REQ-029: After reset, hold alloc_req=1 for 9 cycles -> alloc_ack on 8 cycles with alloc_idx 0..7 in order, then full=1, count=8, and no ack for the 9th request.
- REQ-030: busy_map=8'hFF, release idx 3 -> busy_map=8'hF7 next cycle; then alloc_req -> alloc_idx=3, busy_map=8'hFF.
- REQ-031: busy_map=8'h0F, alloc_req and release idx 1 in the same cycle -> alloc_idx=4, busy_map=8'h1D, count stays 4.
- REQ-032: busy_map=8'hFF, alloc_req and release idx 0 in the same cycle -> alloc_ack=0, busy_map=8'hFE; the next alloc_req grants idx 0.
- REQ-033: busy_map=8'h01, release idx 5 -> rel_err pulses 1 cycle and busy_map stays 8'h01; with INWD=6, release idx 7 -> rel_err pulses.
- REQ-034: busy_map=8'h3F, assert rst_n=0 together with alloc_req -> next cycle busy_map=0, alloc_ack=0, count=0, empty=1.

Source files
------------

// File: rtl/slot_alloc.sv
// slot_alloc: lowest-free-first slot allocator with registered occupancy map, count and release error flag
module slot_alloc #(
  parameter int INWD = 8,
  parameter int LOGINWD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_req,
  output logic               alloc_ack,
  output logic [LOGINWD-1:0] alloc_idx,
  input  logic               rel_valid,
  input  logic [LOGINWD-1:0] rel_idx,
  output logic [INWD-1:0]    busy_map,
  output logic [LOGINWD:0]   count,
  output logic               full,
  output logic               empty,
  output logic               rel_err
);
  logic [LOGINWD-1:0] sel;
  logic               acc;
  logic               rel_ok;
  logic [INWD-1:0]    set_bit;
  logic [INWD-1:0]    clr_bit;
  assign full  = &busy_map;
  assign empty = ~|busy_map;
  // Scanning downward lets the lowest free index win.
  always_comb begin
    sel = '0;
    for (int i = INWD - 1; i >= 0; i--) sel = busy_map[i] ? sel : LOGINWD'(i);
    acc     = alloc_req && !full;
    rel_ok  = rel_valid && (32'(rel_idx) < INWD) && busy_map[rel_idx];
    set_bit = acc ? INWD'(1) << sel : '0;
    clr_bit = rel_ok ? INWD'(1) << rel_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_map  <= '0;
      count     <= '0;
      alloc_ack <= 1'b0;
      alloc_idx <= '0;
      rel_err   <= 1'b0;
    end else begin
      busy_map  <= (busy_map | set_bit) & ~clr_bit;
      count     <= count + (LOGINWD+1)'(acc) - (LOGINWD+1)'(rel_ok);
      alloc_ack <= acc;
      if (acc) alloc_idx <= sel;
      rel_err   <= rel_valid && !rel_ok;
    end
  end
endmodule

// File: tb/tb_slot_alloc.sv
// tb_slot_alloc: directed and randomized checks of slot_alloc against a slot-array reference model
module tb_slot_alloc;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       alloc_req = 0;
  logic       rel_valid = 0;
  logic [2:0] rel_idx = 0;
  logic       alloc_ack;
  logic [2:0] alloc_idx;
  logic [7:0] busy_map;
  logic [3:0] count;
  logic       full, empty, rel_err;

  logic       alloc_req6 = 0;
  logic       rel_valid6 = 0;
  logic [2:0] rel_idx6 = 0;
  logic       alloc_ack6;
  logic [2:0] alloc_idx6;
  logic [5:0] busy6;
  logic [3:0] count6;
  logic       full6, empty6, rel_err6;

  int errors = 0;
  int checks = 0;

  bit m_busy[8];
  bit m_ack, m_err;
  int m_idx;

  slot_alloc #(.INWD(8), .LOGINWD(3)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
    .alloc_idx(alloc_idx), .rel_valid(rel_valid), .rel_idx(rel_idx),
    .busy_map(busy_map), .count(count), .full(full), .empty(empty), .rel_err(rel_err)
  );

  slot_alloc #(.INWD(6), .LOGINWD(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req6), .alloc_ack(alloc_ack6),
    .alloc_idx(alloc_idx6), .rel_valid(rel_valid6), .rel_idx(rel_idx6),
    .busy_map(busy6), .count(count6), .full(full6), .empty(empty6), .rel_err(rel_err6)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_map();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 8; i++) c += m_busy[i];
    return c;
  endfunction

  // One clock of the 8-slot DUT; the model applies the allocation rules directly.
  task automatic step(input bit req, input bit rv, input int ri, input bit rst = 1);
    int  sel = -1;
    bit  acc, legal;
    alloc_req = req; rel_valid = rv; rel_idx = ri[2:0]; rst_n = rst;
    for (int i = 7; i >= 0; i--) if (!m_busy[i]) sel = i;
    acc   = req && sel >= 0;
    legal = rv && ri < 8 && m_busy[ri];
    @(posedge clk); #1;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_busy[i] = 0;
      m_ack = 0; m_idx = 0; m_err = 0;
    end else begin
      m_ack = acc;
      if (acc) begin m_idx = sel; m_busy[sel] = 1; end
      if (legal) m_busy[ri] = 0;
      m_err = rv && !legal;
    end
    alloc_req = 0; rel_valid = 0; rst_n = 1;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0);
    checks++; if (busy_map !== 8'h00) begin errors++; $display("FAIL reset_map got=%h exp=00", busy_map); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (alloc_ack !== 1'b0 || alloc_idx !== 3'd0) begin errors++; $display("FAIL reset_ack got=%b/%0d exp=0/0", alloc_ack, alloc_idx); end
    checks++; if (full !== 1'b0 || empty !== 1'b1 || rel_err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b%b exp=010", full, empty, rel_err); end
    checks++; if (busy6 !== 6'h00 || empty6 !== 1'b1) begin errors++; $display("FAIL reset6 got=%h/%b exp=00/1", busy6, empty6); end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0);
      checks++;
      if (k < 8 && (alloc_ack !== 1'b1 || alloc_idx !== 3'(k))) begin
        errors++; $display("FAIL fill_grant%0d got=%b/%0d exp=1/%0d", k, alloc_ack, alloc_idx, k);
      end else if (k == 8 && (alloc_ack !== 1'b0 || alloc_idx !== 3'd7)) begin
        errors++; $display("FAIL fill_drop got=%b/%0d exp=0/7", alloc_ack, alloc_idx);
      end
    end
    checks++; if (full !== 1'b1 || count !== 4'd8 || busy_map !== 8'hFF) begin errors++; $display("FAIL fill_full got=%b/%0d/%h exp=1/8/ff", full, count, busy_map); end
  endtask

  task automatic test_release_realloc;
    step(0, 1, 3);
    checks++; if (busy_map !== 8'hF7 || count !== 4'd7 || rel_err !== 1'b0) begin errors++; $display("FAIL rel3 got=%h/%0d/%b exp=f7/7/0", busy_map, count, rel_err); end
    step(1, 0, 0);
    checks++; if (alloc_ack !== 1'b1 || alloc_idx !== 3'd3 || busy_map !== 8'hFF) begin errors++; $display("FAIL realloc3 got=%b/%0d/%h exp=1/3/ff", alloc_ack, alloc_idx, busy_map); end
  endtask

  task automatic test_full_release;
    step(1, 1, 0);
    checks++; if (alloc_ack !== 1'b0 || busy_map !== 8'hFE || count !== 4'd7) begin errors++; $display("FAIL full_rel got=%b/%h/%0d exp=0/fe/7", alloc_ack, busy_map, count); end
    step(1, 0, 0);
    checks++; if (alloc_ack !== 1'b1 || alloc_idx !== 3'd0 || busy_map !== 8'hFF) begin errors++; $display("FAIL full_rel_next got=%b/%0d/%h exp=1/0/ff", alloc_ack, alloc_idx, busy_map); end
  endtask

  task automatic test_simul;
    step(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    step(1, 1, 1);
    checks++; if (alloc_ack !== 1'b1 || alloc_idx !== 3'd4) begin errors++; $display("FAIL simul_idx got=%b/%0d exp=1/4", alloc_ack, alloc_idx); end
    checks++; if (busy_map !== 8'h1D || count !== 4'd4) begin errors++; $display("FAIL simul_map got=%h/%0d exp=1d/4", busy_map, count); end
  endtask

  task automatic test_rel_err;
    step(0, 0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 5);
    checks++; if (rel_err !== 1'b1 || busy_map !== 8'h01 || count !== 4'd1) begin errors++; $display("FAIL relerr_free got=%b/%h/%0d exp=1/01/1", rel_err, busy_map, count); end
    step(0, 0, 0);
    checks++; if (rel_err !== 1'b0) begin errors++; $display("FAIL relerr_pulse got=%b exp=0", rel_err); end
    rel_valid6 = 1; rel_idx6 = 3'd7;
    @(posedge clk); #1;
    rel_valid6 = 0;
    checks++; if (rel_err6 !== 1'b1 || busy6 !== 6'h00 || count6 !== 4'd0) begin errors++; $display("FAIL relerr_range got=%b/%h/%0d exp=1/00/0", rel_err6, busy6, count6); end
    alloc_req6 = 1;
    for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
    alloc_req6 = 0;
    checks++; if (full6 !== 1'b1 || count6 !== 4'd6 || alloc_ack6 !== 1'b0 || alloc_idx6 !== 3'd5) begin errors++; $display("FAIL fill6 got=%b/%0d/%b/%0d exp=1/6/0/5", full6, count6, alloc_ack6, alloc_idx6); end
  endtask

  task automatic test_reset_override;
    step(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 0, 0);
    checks++; if (busy_map !== 8'h3F) begin errors++; $display("FAIL pre_rst_map got=%h exp=3f", busy_map); end
    step(1, 1, 2, 0);
    checks++; if (busy_map !== 8'h00 || alloc_ack !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL rst_override got=%h/%b/%0d/%b exp=00/0/0/1", busy_map, alloc_ack, count, empty); end
  endtask

  task automatic test_random;
    step(0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 7), $urandom_range(0, 99) != 0);
      checks++;
      if (busy_map !== m_map() || count !== 4'(m_cnt()) || alloc_ack !== m_ack || alloc_idx !== 3'(m_idx) ||
          rel_err !== m_err || full !== (m_cnt() == 8) || empty !== (m_cnt() == 0)) begin
        errors++;
        $display("FAIL rand%0d got=%h/%0d/%b/%0d/%b/%b%b exp=%h/%0d/%b/%0d/%b/%b%b", n,
                 busy_map, count, alloc_ack, alloc_idx, rel_err, full, empty,
                 m_map(), m_cnt(), m_ack, m_idx, m_err, m_cnt() == 8, m_cnt() == 0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_release_realloc;
    test_full_release;
    test_simul;
    test_rel_err;
    test_reset_override;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
